// File: rtl/config_pkg.sv
// Global configuration shared by the front-end blocks.
package config_pkg;

    typedef struct packed {
        int unsigned PLEN;
    } cfg_t;

    // Default configuration: 32-bit physical addresses.
    localparam cfg_t EmptyCfg = '{PLEN: 32'd32};

endpackage

// File: rtl/ittage_pkg.sv
// Types and helpers for the ITTAGE update path.
package ittage_pkg;

    // Storage sizing for one buffered update. Module parameters default to
    // these values; overriding them means changing the package as well.
    localparam int unsigned UPD_PLEN    = config_pkg::EmptyCfg.PLEN;
    localparam int unsigned UPD_PHB     = 16;
    localparam int unsigned STAT_CNT_W  = 16;

    typedef struct packed {
        logic [UPD_PLEN-1:0] pc;
        logic [UPD_PHB-1:0]  ctx;
        logic [UPD_PLEN-1:0] target;
    } ittage_upd_t;

    // Duplicate test: whole payload must match.
    function automatic logic upd_eq(input ittage_upd_t a, input ittage_upd_t b);
        return (a == b);
    endfunction

    // Add 0..3 to a statistic counter, sticking at all-ones.
    function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v,
                                                      input logic [1:0]            inc);
        logic [STAT_CNT_W:0] sum;
        sum = {1'b0, v} + {{(STAT_CNT_W-1){1'b0}}, inc};
        return sum[STAT_CNT_W] ? {STAT_CNT_W{1'b1}} : sum[STAT_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/ittage_update_ctrl.sv
// Buffers resolved indirect-jump updates from commit and drains them one per
// cycle onto the single-ported ITTAGE update interface. Commit is never
// stalled: overflow is dropped and counted, back-to-back repeats are squashed.
module ittage_update_ctrl
    import ittage_pkg::*;
#(
    parameter config_pkg::cfg_t Cfg            = config_pkg::EmptyCfg,
    parameter int unsigned      NUM_ENQ        = 2,
    parameter int unsigned      DEPTH          = 8,
    parameter int unsigned      PATH_HIST_BITS = UPD_PHB,
    parameter int unsigned      CNT_W          = STAT_CNT_W
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_ENQ-1:0]                enq_valid_i,
    input  logic [NUM_ENQ*Cfg.PLEN-1:0]       enq_pc_i,
    input  logic [NUM_ENQ*PATH_HIST_BITS-1:0] enq_ctx_i,
    input  logic [NUM_ENQ*Cfg.PLEN-1:0]       enq_target_i,
    input  logic                              drain_en_i,
    input  logic                              flush_i,
    output logic                              update_valid_o,
    output logic [Cfg.PLEN-1:0]               update_pc_o,
    output logic [PATH_HIST_BITS-1:0]         update_ctx_o,
    output logic [Cfg.PLEN-1:0]               update_target_o,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy_o,
    output logic [CNT_W-1:0]                  drop_cnt_o,
    output logic [CNT_W-1:0]                  dup_cnt_o
);

    localparam int unsigned PLEN = Cfg.PLEN;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH+1);

    // Ring storage and pointers.
    ittage_upd_t      r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_dup_cnt;

    // Unpacked enqueue payloads.
    ittage_upd_t w_in [NUM_ENQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENQ; gi++) begin : g_unpack
            assign w_in[gi] = '{pc:     enq_pc_i[gi*PLEN +: PLEN],
                                ctx:    enq_ctx_i[gi*PATH_HIST_BITS +: PATH_HIST_BITS],
                                target: enq_target_i[gi*PLEN +: PLEN]};
        end
    endgenerate

    logic          w_nonempty;
    logic          w_issue;
    logic [AW-1:0] w_last_idx;
    ittage_upd_t   w_last;
    ittage_upd_t   w_head;
    ittage_upd_t   w_p0;
    ittage_upd_t   w_p1;
    logic          w_v0;
    logic          w_v1;
    logic [CW:0]   w_free;
    logic          w_dup0;
    logic          w_dup1;
    logic          w_wr0;
    logic          w_wr1;
    logic          w_drop0;
    logic          w_drop1;
    logic [AW-1:0] w_wr1_idx;
    logic [1:0]    w_drop_inc;
    logic [1:0]    w_dup_inc;

    assign w_nonempty = (r_count != '0);
    assign w_issue    = w_nonempty & drain_en_i & ~flush_i;
    assign w_last_idx = r_tail - AW'(1);
    assign w_last     = r_mem[w_last_idx];
    assign w_head     = r_mem[r_head];
    assign w_p0       = w_in[0];
    assign w_p1       = w_in[NUM_ENQ-1];
    // Flush discards incoming requests entirely, so they never reach the
    // dup/drop accounting.
    assign w_v0       = enq_valid_i[0] & ~flush_i;
    assign w_v1       = (NUM_ENQ > 1) & enq_valid_i[NUM_ENQ-1] & ~flush_i;

    // Enqueue decision: duplicate filter, then space check in port order.
    always_comb begin
        w_free  = (CW+1)'(DEPTH) - {1'b0, r_count} + {{CW{1'b0}}, w_issue};
        // The slot at tail-1 is the comparison point even if it pops now.
        w_dup0  = w_v0 & w_nonempty & upd_eq(w_p0, w_last);
        w_wr0   = w_v0 & ~w_dup0 & (w_free != '0);
        w_drop0 = w_v0 & ~w_dup0 & (w_free == '0);
        // Port 1 compares against port 0 when port 0 lands this cycle.
        w_dup1  = w_v1 & (w_wr0 ? upd_eq(w_p1, w_p0)
                                : (w_nonempty & upd_eq(w_p1, w_last)));
        w_wr1   = w_v1 & ~w_dup1 & (w_free > (CW+1)'(w_wr0));
        w_drop1 = w_v1 & ~w_dup1 & ~w_wr1;
        w_wr1_idx  = r_tail + AW'(w_wr0);
        w_drop_inc = {1'b0, w_drop0} + {1'b0, w_drop1};
        w_dup_inc  = {1'b0, w_dup0} + {1'b0, w_dup1};
    end

    // Payload storage: no reset, outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (w_wr0) r_mem[r_tail]    <= w_p0;
        if (w_wr1) r_mem[w_wr1_idx] <= w_p1;
    end

    // Pointers, occupancy and statistics.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
            r_dup_cnt  <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head     <= r_head + AW'(w_issue);
            r_tail     <= r_tail + AW'(w_wr0) + AW'(w_wr1);
            r_count    <= r_count + CW'(w_wr0) + CW'(w_wr1) - CW'(w_issue);
            r_drop_cnt <= sat_inc(r_drop_cnt, w_drop_inc);
            r_dup_cnt  <= sat_inc(r_dup_cnt, w_dup_inc);
        end
    end

    assign update_valid_o  = w_issue;
    assign update_pc_o     = w_nonempty ? w_head.pc     : '0;
    assign update_ctx_o    = w_nonempty ? w_head.ctx    : '0;
    assign update_target_o = w_nonempty ? w_head.target : '0;
    assign occupancy_o     = r_count;
    assign drop_cnt_o      = r_drop_cnt;
    assign dup_cnt_o       = r_dup_cnt;

endmodule
